// File: rtl/smachine_program_loader_if.sv
// Byte stream into the loader plus the instruction-memory write port it drives.
// Latency: none (wires only).
// Backpressure: in_ready qualifies in_valid; the memory port has no backpressure.
interface smachine_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;

  // Producer side: image source and memory observer.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/smachine_program_loader.sv
// Boot loader: streams LEN, N x {HI,LO}, CSUM into instruction memory, then enables the CPU.
// Latency: write strobe and final status appear one cycle after the accepting transfer.
// Backpressure: in_ready is high only while a load is in progress; in_valid gaps stall the FSM.
module smachine_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  smachine_program_loader_if.slave      bus,
  output logic                          cpu_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]            state;
  // One bit wider than the address so the compare with N never wraps.
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic [7:0]            csum;
  logic [7:0]            hi;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  loading;
  logic                  xfer;

  // Status flags decode straight from the registered state.
  always_comb begin
    loading    = (state == S_LEN) || (state == S_HI) ||
                 (state == S_LO)  || (state == S_CSUM);
    xfer       = loading && bus.in_valid;
    cnt_nxt    = cnt + 1'b1;
    busy       = loading;
    cpu_enable = (state == S_RUN);
    done       = (state == S_RUN);
    error      = (state == S_ERR);
  end

  assign bus.in_ready  = loading;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Load sequencer: parses the stream, issues word writes, checks the XOR sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      cnt       <= '0;
      csum      <= '0;
      hi        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Strobe lasts one cycle; address and data hold afterwards.
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LEN;
        end
        S_LEN: begin
          if (xfer) begin
            len   <= (ADDR_WIDTH+1)'(bus.in_data);
            csum  <= bus.in_data;
            cnt   <= '0;
            state <= (bus.in_data == 8'd0) ? S_CSUM : S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi    <= bus.in_data;
            csum  <= csum ^ bus.in_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            csum      <= csum ^ bus.in_data;
            mem_we    <= 1'b1;
            mem_addr  <= cnt[ADDR_WIDTH-1:0];
            mem_wdata <= {hi, bus.in_data};
            cnt       <= cnt_nxt;
            state     <= (cnt_nxt == len) ? S_CSUM : S_HI;
          end
        end
        S_CSUM: begin
          if (xfer) state <= (bus.in_data == csum) ? S_RUN : S_ERR;
        end
        S_RUN, S_ERR: begin
          // A new load immediately withdraws the CPU enable.
          if (start) state <= S_LEN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smachine_program_loader.sv
// Bench for smachine_program_loader: directed boot scenarios plus random images.
// Expected writes and final status come from a byte-level model of the image format.
module tb_smachine_program_loader;

  logic clk;
  logic reset;
  logic start;
  logic cpu_enable, busy, done, error;
  int   tests;
  int   fails;

  smachine_program_loader_if #(.ADDR_WIDTH(8)) bus();

  smachine_program_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image under test and the writes it must produce ({addr, data}).
  logic [15:0] img[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every write strobe must match the next expected word, in order.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_write: got %0h expected none", {bus.mem_addr, bus.mem_wdata});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        assert ({bus.mem_addr, bus.mem_wdata} === e) else begin
          fails++;
          $error("FAIL write: got %0h expected %0h", {bus.mem_addr, bus.mem_wdata}, e);
        end
      end
    end
    // The CPU may only be enabled together with done, outside any load.
    if (!reset && (cpu_enable || done)) begin
      tests++;
      assert (cpu_enable && done && !busy && !error) else begin
        fails++;
        $error("FAIL run_flags: got en=%0b done=%0b busy=%0b err=%0b expected 1 1 0 0",
               cpu_enable, done, busy, error);
      end
    end
  end

  // gap_mode: 0 back-to-back, 1 two idle cycles before every other byte, 2 random idles.
  task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit midstart,
                           inout int nb);
    int gap;
    gap = 0;
    if (gap_mode == 1) gap = (nb % 2 == 1) ? 2 : 0;
    else if (gap_mode == 2) gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      start        = midstart && (g == 0);
      @(posedge clk); #1;
      start        = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    chk("in_ready_during_load", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    nb++;
  endtask

  // Streams img; cs_force selects an explicit CSUM byte instead of the correct one.
  // stop_words > 0 abandons the stream after that many words have been written.
  task automatic load(input int gap_mode, input bit midstart, input bit cs_force,
                      input logic [7:0] cs_val, input int stop_words);
    logic [7:0] lenb, model, sent;
    bit         good;
    int         nb;
    nb    = 0;
    lenb  = 8'(img.size());
    model = lenb;
    for (int i = 0; i < img.size(); i++) model = model ^ img[i][15:8] ^ img[i][7:0];
    sent  = cs_force ? cs_val : model;
    good  = (sent == model);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_ready", 32'(bus.in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_cpu_enable", 32'(cpu_enable), 0);
    chk("start_done", 32'(done), 0);
    chk("start_error", 32'(error), 0);

    send_byte(lenb, gap_mode, midstart, nb);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({8'(i), img[i]});
      send_byte(img[i][15:8], gap_mode, midstart, nb);
      send_byte(img[i][7:0], gap_mode, midstart, nb);
      if (i + 1 == stop_words) begin
        bus.in_valid = 1'b0;
        @(negedge clk); #1;
        return;
      end
    end
    send_byte(sent, gap_mode, midstart, nb);
    bus.in_valid = 1'b0;
    chk("end_done", 32'(done), 32'(good));
    chk("end_cpu_enable", 32'(cpu_enable), 32'(good));
    chk("end_error", 32'(error), 32'(!good));
    chk("end_busy", 32'(busy), 0);
    chk("end_in_ready", 32'(bus.in_ready), 0);
    chk("writes_outstanding", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_cpu_enable"}, 32'(cpu_enable), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Boot: held in reset, then idle with no start.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("boot_cpu_enable", 32'(cpu_enable), 0);
    chk("boot_in_ready", 32'(bus.in_ready), 0);
    chk("boot_busy", 32'(busy), 0);

    // Nominal three-word image.
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    load(0, 1'b0, 1'b0, 8'h00, 0);

    // Bad checksum, then recovery with a good image.
    load(0, 1'b0, 1'b1, 8'h7F, 0);
    load(0, 1'b0, 1'b0, 8'h00, 0);

    // Empty image: good then bad checksum.
    img.delete();
    load(0, 1'b0, 1'b0, 8'h00, 0);
    load(0, 1'b0, 1'b1, 8'h01, 0);

    // Gapped stream with start pulses during the load.
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    load(1, 1'b1, 1'b0, 8'h00, 0);

    // Reset right after the second word is written.
    load(0, 1'b0, 1'b0, 8'h00, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_all_zero("midreset");
    chk("midreset_writes", 32'(exp_q.size()), 0);
    img = '{16'hAA55};
    load(0, 1'b0, 1'b0, 8'h00, 0);

    // Random images, random gaps, occasional wrong checksum.
    repeat (8) begin
      int n;
      n = int'($urandom_range(0, 8));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      load(2, 1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom), 0);
    end

    // One longer image.
    img.delete();
    for (int i = 0; i < 40; i++) img.push_back(16'($urandom));
    load(0, 1'b0, 1'b0, 8'h00, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
